// File: rtl/flappy_score_unit.sv
// Game status for Flappy Bird: pipe collision, sticky game-over, pass score, 7-seg decode, gap LFSR.
// Optional macro FLOOR_COLLISION_EN: floor/ceiling contact also ends the game.
module flappy_score_unit #(
  parameter int         SCORE_MAX     = 99,
  parameter int         SCREEN_BOTTOM = 479,
  parameter logic [9:0] LFSR_SEED     = 10'h000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] bird_x0,
  input  logic [9:0] bird_x1,
  input  logic [8:0] bird_y0,
  input  logic [8:0] bird_y1,
  input  logic [9:0] pipe1_x0,
  input  logic [9:0] pipe1_x1,
  input  logic [8:0] pipe1_y0,
  input  logic [8:0] pipe1_y1,
  input  logic [9:0] pipe2_x0,
  input  logic [9:0] pipe2_x1,
  input  logic [8:0] pipe2_y0,
  input  logic [8:0] pipe2_y1,
  input  logic [9:0] pipe3_x0,
  input  logic [9:0] pipe3_x1,
  input  logic [8:0] pipe3_y0,
  input  logic [8:0] pipe3_y1,
  output logic [6:0] score,
  output logic       game_over,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [9:0] pipe_length
);

  localparam logic [6:0] SCORE_SAT = 7'(SCORE_MAX);
  localparam logic [8:0] FLOOR_ROW = 9'(SCREEN_BOTTOM);
`ifdef FLOOR_COLLISION_EN
  localparam logic FLOOR_EN = 1'b1;
`else
  localparam logic FLOOR_EN = 1'b0;
`endif

  logic [9:0] px0 [3];
  logic [9:0] px1 [3];
  logic [8:0] py0 [3];
  logic [8:0] py1 [3];

  assign px0[0] = pipe1_x0;
  assign px0[1] = pipe2_x0;
  assign px0[2] = pipe3_x0;
  assign px1[0] = pipe1_x1;
  assign px1[1] = pipe2_x1;
  assign px1[2] = pipe3_x1;
  assign py0[0] = pipe1_y0;
  assign py0[1] = pipe2_y0;
  assign py0[2] = pipe3_y0;
  assign py1[0] = pipe1_y1;
  assign py1[1] = pipe2_y1;
  assign py1[2] = pipe3_y1;

  logic [2:0] hit;
  logic [2:0] passed_now;
  logic [2:0] passed_q;
  logic [2:0] pass_evt;
  logic       bound_hit;
  logic       any_hit;
  logic [1:0] pass_cnt;
  logic [7:0] score_sum;
  logic [6:0] score_next;
  logic [6:0] tens;
  logic [6:0] ones;

  // A pipe is solid outside its gap, so either vertical edge overlapping counts as a hit.
  always_comb begin
    hit        = '0;
    passed_now = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = (bird_x1 >= px0[i]) && (bird_x0 <= px1[i]) &&
               ((bird_y0 <= py1[i]) || (bird_y1 >= py0[i]));
      passed_now[i] = (px1[i] < bird_x0);
    end
  end

  assign bound_hit = FLOOR_EN && ((bird_y1 >= FLOOR_ROW) || (bird_y0 == 9'd0));
  assign any_hit   = (|hit) || bound_hit;
  assign pass_evt  = passed_now & ~passed_q;

  always_comb begin
    pass_cnt   = {1'b0, pass_evt[0]} + {1'b0, pass_evt[1]} + {1'b0, pass_evt[2]};
    score_sum  = {1'b0, score} + {6'b0, pass_cnt};
    score_next = (score_sum >= {1'b0, SCORE_SAT}) ? SCORE_SAT : score_sum[6:0];
  end

  // Collision wins over scoring in the cycle it happens; afterwards the score is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score       <= '0;
      game_over   <= 1'b0;
      passed_q    <= '0;
      pipe_length <= LFSR_SEED;
    end else begin
      pipe_length <= {pipe_length[8:0], ~(pipe_length[9] ^ pipe_length[6])};
      passed_q    <= passed_now;
      if (!game_over) begin
        if (any_hit) begin
          game_over <= 1'b1;
        end else begin
          score <= score_next;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [6:0] d);
    case (d)
      7'd0:    seg7 = 7'b1000000;
      7'd1:    seg7 = 7'b1111001;
      7'd2:    seg7 = 7'b0100100;
      7'd3:    seg7 = 7'b0110000;
      7'd4:    seg7 = 7'b0011001;
      7'd5:    seg7 = 7'b0010010;
      7'd6:    seg7 = 7'b0000010;
      7'd7:    seg7 = 7'b1111000;
      7'd8:    seg7 = 7'b0000000;
      7'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tens = score / 7'd10;
  assign ones = score % 7'd10;
  assign HEX0 = seg7(ones);
  assign HEX1 = (score < 7'd10) ? 7'h7F : seg7(tens);

endmodule

// File: tb/tb_flappy_score_unit.sv
// Scoreboard bench for flappy_score_unit: a rule-level model predicts each cycle, a monitor compares.
module tb_flappy_score_unit;

  logic       clk;
  logic       reset;
  logic [9:0] bx0, bx1;
  logic [8:0] by0, by1;
  logic [9:0] px0 [3];
  logic [9:0] px1 [3];
  logic [8:0] py0 [3];
  logic [8:0] py1 [3];
  logic [6:0] score;
  logic       game_over;
  logic [6:0] hex0, hex1;
  logic [9:0] pipe_length;

  flappy_score_unit dut (
    .clk(clk), .reset(reset),
    .bird_x0(bx0), .bird_x1(bx1), .bird_y0(by0), .bird_y1(by1),
    .pipe1_x0(px0[0]), .pipe1_x1(px1[0]), .pipe1_y0(py0[0]), .pipe1_y1(py1[0]),
    .pipe2_x0(px0[1]), .pipe2_x1(px1[1]), .pipe2_y0(py0[1]), .pipe2_y1(py1[1]),
    .pipe3_x0(px0[2]), .pipe3_x1(px1[2]), .pipe3_y0(py0[2]), .pipe3_y1(py1[2]),
    .score(score), .game_over(game_over), .HEX0(hex0), .HEX1(hex1),
    .pipe_length(pipe_length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int score;
    int go;
    int h0;
    int h1;
    int pl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Staged stimulus; copied onto the DUT inputs only at a falling edge.
  int s_bx0, s_by0;
  int s_px0 [3];
  int s_px1 [3];
  int s_py0 [3];
  int s_py1 [3];

  // Reference model state
  int m_score, m_go, m_lfsr;
  int m_prev [3];

  task automatic checkOutput(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void modelReset();
    m_score = 0;
    m_go    = 0;
    m_lfsr  = 0;
    for (int i = 0; i < 3; i++) m_prev[i] = 0;
  endfunction

  function automatic void modelStep();
    int hits = 0;
    int passes = 0;
    int now;
    for (int i = 0; i < 3; i++) begin
      if (int'(bx1) >= int'(px0[i]) && int'(bx0) <= int'(px1[i]) &&
          (int'(by0) <= int'(py1[i]) || int'(by1) >= int'(py0[i])))
        hits++;
      now = (int'(px1[i]) < int'(bx0)) ? 1 : 0;
      if (now == 1 && m_prev[i] == 0) passes++;
      m_prev[i] = now;
    end
`ifdef FLOOR_COLLISION_EN
    if (int'(by1) >= 479 || int'(by0) == 0) hits++;
`endif
    if (m_go == 0 && hits == 0) m_score = (m_score + passes > 99) ? 99 : m_score + passes;
    if (hits > 0) m_go = 1;
    m_lfsr = ((m_lfsr * 2) % 1024) + ((((m_lfsr / 512) % 2) == ((m_lfsr / 64) % 2)) ? 1 : 0);
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.score = m_score;
    e.go    = m_go;
    e.h0    = int'(seg_tab[m_score % 10]);
    e.h1    = (m_score < 10) ? 'h7F : int'(seg_tab[m_score / 10]);
    e.pl    = m_lfsr;
    return e;
  endfunction

  task automatic driveAndPredict();
    bx0 = 10'(s_bx0);
    bx1 = 10'(s_bx0 + 15);
    by0 = 9'(s_by0);
    by1 = 9'(s_by0 + 15);
    for (int i = 0; i < 3; i++) begin
      px0[i] = 10'(s_px0[i]);
      px1[i] = 10'(s_px1[i]);
      py0[i] = 9'(s_py0[i]);
      py1[i] = 9'(s_py1[i]);
    end
    modelStep();
    exp_q.push_back(expected());
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    driveAndPredict();
  endtask

  task automatic setPipe(input int i, input int x0, input int x1, input int y1, input int y0);
    s_px0[i] = x0;
    s_px1[i] = x1;
    s_py1[i] = y1;
    s_py0[i] = y0;
  endtask

  task automatic parkAll();
    for (int i = 0; i < 3; i++) setPipe(i, 700, 750, 100, 300);
  endtask

  // Reset is checked at once, with no clock edge in between, to prove it is asynchronous.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_game_over", int'(game_over), 0);
    checkOutput("rst_hex0", int'(hex0), 'h40);
    checkOutput("rst_hex1", int'(hex1), 'h7F);
    checkOutput("rst_pipe_length", int'(pipe_length), 0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    driveAndPredict();
  endtask

  task automatic pumpPass(input int n);
    for (int k = 0; k < n; k++) begin
      setPipe(0, 60, 110, 150, 260);
      applyStimulus();
      setPipe(0, 40, 90, 150, 260);
      applyStimulus();
    end
  endtask

  task automatic randomBlock(input int n);
    int d;
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        s_bx0 = int'($urandom_range(0, 600));
        s_by0 = int'($urandom_range(100, 300));
      end
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_px0[i] = int'($urandom_range(0, 700));
          s_px1[i] = s_px0[i] + int'($urandom_range(10, 60));
          if ($urandom_range(0, 9) != 0) begin
            s_py1[i] = s_by0 - int'($urandom_range(1, 60));
            s_py0[i] = s_by0 + 15 + int'($urandom_range(1, 60));
          end else begin
            s_py1[i] = int'($urandom_range(0, 240));
            s_py0[i] = s_py1[i] + int'($urandom_range(0, 240));
          end
        end else begin
          d = int'($urandom_range(0, 3));
          if (s_px0[i] >= d) begin
            s_px0[i] -= d;
            s_px1[i] -= d;
          end
        end
      end
      applyStimulus();
    end
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("score", int'(score), mon_e.score);
      checkOutput("game_over", int'(game_over), mon_e.go);
      checkOutput("hex0", int'(hex0), mon_e.h0);
      checkOutput("hex1", int'(hex1), mon_e.h1);
      checkOutput("pipe_length", int'(pipe_length), mon_e.pl);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    s_bx0 = 100;
    s_by0 = 200;
    parkAll();
    modelReset();
    driveAndPredict();
    exp_q.delete();

    // LFSR: first step and full period
    doReset();
    @(posedge clk);
    #2;
    checkOutput("lfsr_first_step", int'(pipe_length), 1);
    for (int k = 0; k < 1022; k++) applyStimulus();
    @(posedge clk);
    #2;
    checkOutput("lfsr_period", int'(pipe_length), 0);

    // Pipe 1 slides left through the gap: exactly one point
    for (int k = 0; k <= 80; k++) begin
      setPipe(0, 120 - k, 170 - k, 150, 260);
      applyStimulus();
    end
    @(posedge clk);
    #2;
    checkOutput("pass_once", int'(score), 1);

    // Collision: sticky game-over, score frozen even when a pipe passes later
    setPipe(0, 110, 160, 205, 300);
    applyStimulus();
    parkAll();
    for (int k = 0; k < 4; k++) applyStimulus();
    setPipe(1, 60, 110, 150, 260);
    applyStimulus();
    setPipe(1, 40, 90, 150, 260);
    for (int k = 0; k < 3; k++) applyStimulus();
    doReset();

    // Collision and pass in the same cycle: no point
    parkAll();
    setPipe(1, 60, 110, 150, 260);
    applyStimulus();
    setPipe(1, 40, 90, 150, 260);
    setPipe(0, 110, 160, 205, 300);
    for (int k = 0; k < 3; k++) applyStimulus();
    doReset();

    // Double pass at 5 -> 7, then saturation at 99
    parkAll();
    pumpPass(5);
    setPipe(1, 60, 110, 150, 260);
    setPipe(2, 60, 110, 150, 260);
    applyStimulus();
    setPipe(1, 40, 90, 150, 260);
    setPipe(2, 40, 90, 150, 260);
    applyStimulus();
    pumpPass(91);
    setPipe(1, 60, 110, 150, 260);
    setPipe(2, 60, 110, 150, 260);
    applyStimulus();
    setPipe(1, 40, 90, 150, 260);
    setPipe(2, 40, 90, 150, 260);
    applyStimulus();
    pumpPass(3);
    doReset();

    // Floor and ceiling with no pipe overlap
    parkAll();
    s_by0 = 464;
    for (int k = 0; k < 3; k++) applyStimulus();
    doReset();
    s_by0 = 0;
    for (int k = 0; k < 3; k++) applyStimulus();
    doReset();

    for (int b = 0; b < 6; b++) begin
      s_bx0 = 100;
      s_by0 = 200;
      parkAll();
      doReset();
      randomBlock(200);
    end

    @(posedge clk);
    #2;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
